// File: rtl/vga_timing_pkg.sv
// Shared raster constants, axis-total helper and coordinate type for the VGA timing generator.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;
  localparam int unsigned FC_W_DEF     = 16;

  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  localparam int unsigned H_TOTAL_DEF = axis_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int unsigned V_TOTAL_DEF = axis_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: counts 0..TOTAL-1 when enabled, flags the wrap and exposes the next value.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned TOTAL = 800
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   en,
  output coord_t count,
  output coord_t count_next,
  output logic   wrap
);

  localparam coord_t LAST = coord_t'(TOTAL - 1);

  always_comb begin
    wrap       = en && (count == LAST);
    count_next = count;
    if (wrap)    count_next = '0;
    else if (en) count_next = count + coord_t'(1);
  end

  // Resetting to the terminal count makes the first enabled step land on 0.
  always_ff @(posedge clk) begin
    if (reset) count <= LAST;
    else       count <= count_next;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing generator: coordinates, blank, active-low syncs, frame strobe/count.
// Optional VGA_SYNC_ALIGN_EN delays hs/vs by one enabled pixel to line up with registered RGB.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned FC_W     = FC_W_DEF
) (
  input  logic            vga_clk,
  input  logic            reset,
  input  logic            pix_en,
  output logic [9:0]      DrawX,
  output logic [9:0]      DrawY,
  output logic            blank,
  output logic            hs,
  output logic            vs,
  output logic            frame_start,
  output logic [FC_W-1:0] frame_count
);

  localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam coord_t H_ACT_C  = coord_t'(H_ACTIVE);
  localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t V_ACT_C  = coord_t'(V_ACTIVE);
  localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  coord_t x_next, y_next;
  logic   h_wrap, v_wrap, v_en;
  logic   blank_next, hs_next, vs_next;
  logic   hs_q, vs_q;

  assign v_en = pix_en & h_wrap;

  vga_axis_counter #(.TOTAL(H_TOTAL)) u_h (
    .clk(vga_clk), .reset(reset), .en(pix_en),
    .count(DrawX), .count_next(x_next), .wrap(h_wrap)
  );

  vga_axis_counter #(.TOTAL(V_TOTAL)) u_v (
    .clk(vga_clk), .reset(reset), .en(v_en),
    .count(DrawY), .count_next(y_next), .wrap(v_wrap)
  );

  // Decode from next-state counters so the registered flags match the coordinate they accompany.
  always_comb begin
    blank_next = (x_next < H_ACT_C) && (y_next < V_ACT_C);
    hs_next    = !((x_next >= HS_START) && (x_next < HS_END));
    vs_next    = !((y_next >= VS_START) && (y_next < VS_END));
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      blank       <= 1'b0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      blank       <= blank_next;
      hs_q        <= hs_next;
      vs_q        <= vs_next;
      frame_start <= v_wrap;
      if (v_wrap) frame_count <= frame_count + FC_W'(1);
    end
  end

`ifdef VGA_SYNC_ALIGN_EN
  logic hs_d, vs_d;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hs_d <= 1'b1;
      vs_d <= 1'b1;
    end else if (pix_en) begin
      hs_d <= hs_q;
      vs_d <= vs_q;
    end
  end

  assign hs = hs_d;
  assign vs = vs_d;
`else
  assign hs = hs_q;
  assign vs = vs_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a linear-pixel-index raster model queues expected outputs; a monitor compares.
module tb_vga_timing_gen;

  localparam int H_ACT = 640, H_FP = 16, H_SY = 96, H_BP = 48;
  localparam int V_ACT = 6, V_FP = 1, V_SY = 2, V_BP = 1;
  localparam int FC_W  = 2;
  localparam int HT    = H_ACT + H_FP + H_SY + H_BP;
  localparam int VT    = V_ACT + V_FP + V_SY + V_BP;
  localparam int FRAME = HT * VT;

  logic            vga_clk = 1'b0;
  logic            reset   = 1'b1;
  logic            pix_en  = 1'b1;
  logic [9:0]      DrawX, DrawY;
  logic            blank, hs, vs, frame_start;
  logic [FC_W-1:0] frame_count;

  typedef struct packed {
    logic [9:0]      x;
    logic [9:0]      y;
    logic            blank;
    logic            hs;
    logic            vs;
    logic            fs;
    logic [FC_W-1:0] fc;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_e, mon_a;
  int   compared   = 0;
  int   mismatched = 0;

  int              pos;
  logic            m_blank, m_hs, m_vs, m_fs, m_hs_al, m_vs_al;
  logic [FC_W-1:0] m_fc;

  vga_timing_gen #(
    .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SY), .H_BP(H_BP),
    .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP),
    .FC_W(FC_W)
  ) dut (
    .vga_clk(vga_clk), .reset(reset), .pix_en(pix_en),
    .DrawX(DrawX), .DrawY(DrawY), .blank(blank), .hs(hs), .vs(vs),
    .frame_start(frame_start), .frame_count(frame_count)
  );

  always #5 vga_clk = ~vga_clk;

  // Drive one clock of stimulus and queue what the raster must show after that edge.
  task automatic step(input bit r, input bit e);
    obs_t o;
    int   x, y;
    @(negedge vga_clk);
    reset  = r;
    pix_en = e;
    m_fs   = 1'b0;
    if (r) begin
      pos = FRAME - 1;
      m_fc = '0;
      m_blank = 1'b0; m_hs = 1'b1; m_vs = 1'b1; m_hs_al = 1'b1; m_vs_al = 1'b1;
    end else if (e) begin
      pos = (pos + 1) % FRAME;
      if (pos == 0) begin
        m_fs = 1'b1;
        m_fc = m_fc + 1'b1;
      end
      x = pos % HT;
      y = pos / HT;
      m_hs_al = m_hs;
      m_vs_al = m_vs;
      m_blank = (x < H_ACT) && (y < V_ACT);
      m_hs    = !((x >= H_ACT + H_FP) && (x < H_ACT + H_FP + H_SY));
      m_vs    = !((y >= V_ACT + V_FP) && (y < V_ACT + V_FP + V_SY));
    end
    o.x     = 10'(pos % HT);
    o.y     = 10'(pos / HT);
    o.blank = m_blank;
`ifdef VGA_SYNC_ALIGN_EN
    o.hs    = m_hs_al;
    o.vs    = m_vs_al;
`else
    o.hs    = m_hs;
    o.vs    = m_vs;
`endif
    o.fs    = m_fs;
    o.fc    = m_fc;
    exp_q.push_back(o);
  endtask

  initial begin
    forever begin
      @(posedge vga_clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_a = {DrawX, DrawY, blank, hs, vs, frame_start, frame_count};
        compared++;
        if (mon_a !== mon_e) begin
          mismatched++;
          $display("FAIL raster @%0t: got x=%0d y=%0d blank=%b hs=%b vs=%b fs=%b fc=%0d, want x=%0d y=%0d blank=%b hs=%b vs=%b fs=%b fc=%0d",
                   $time, mon_a.x, mon_a.y, mon_a.blank, mon_a.hs, mon_a.vs, mon_a.fs, mon_a.fc,
                   mon_e.x, mon_e.y, mon_e.blank, mon_e.hs, mon_e.vs, mon_e.fs, mon_e.fc);
        end
      end
    end
  end

  initial begin
    int tgt;
    repeat (3) step(1'b1, 1'b1);
    repeat (2 * HT) step(1'b0, 1'b1);
    repeat (FRAME) step(1'b0, 1'b1);
    for (int i = 0; i < 2 * HT + 50; i++) step(1'b0, i[0]);
    repeat (6000) step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1);
    // Mid-frame reset at a known coordinate.
    step(1'b1, 1'b0);
    tgt = (V_ACT / 2) * HT + 300;
    for (int k = 0; k < FRAME && pos != tgt; k++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    // Enough full frames to wrap the narrow frame counter.
    repeat (4 * FRAME + 10) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    @(posedge vga_clk);
    #2;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
